// File: rtl/csa_slice_seq_adder.sv
// csa_slice_seq_adder
//
// Multi-cycle wide adder. A WIDTH-bit addition A+B+cin is computed one byte
// at a time, least-significant byte first, through a single 8-bit
// carry-skip adder slice. The carry out of each slice is registered and used
// as the carry into the next slice. Operands are taken on an in_valid/in_ready
// handshake, and the result is offered on an out_valid/out_ready handshake.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset (dominant)
//   in_valid   operand set present
//   in_ready   block idle and able to accept operands
//   a, b       WIDTH-bit operands
//   cin        carry into slice 0
//   out_valid  result valid (held until out_ready)
//   out_ready  consumer accepts the result
//   sum        A+B+cin modulo 2^WIDTH
//   cout       carry out of the final slice
//   ovf        two's-complement overflow of the full-width sum
//   busy       high while an operation is in flight or waiting for pickup

module csa_slice_seq_adder #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NSL  = WIDTH / SLICE;
  localparam int IDXW = (NSL > 1) ? $clog2(NSL) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q,   idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q,     a_d;
  logic [WIDTH-1:0]  b_q,     b_d;
  logic [WIDTH-1:0]  sum_q,   sum_d;
  logic              cout_q,  cout_d;
  logic              ovf_q,   ovf_d;

  logic [7:0]        sl_a, sl_b, sl_sum;
  logic              sl_cin, sl_cout;
  logic              last_slice;

  assign last_slice = (idx_q == IDXW'(NSL - 1));

  // Operand bytes for the current slice come from the captured operands, so
  // the a/b inputs are free to change once the operation has been accepted.
  assign sl_a   = a_q[int'(idx_q)*SLICE +: SLICE];
  assign sl_b   = b_q[int'(idx_q)*SLICE +: SLICE];
  assign sl_cin = carry_q;

  // 8-bit carry-skip slice built from two 4-bit ripple blocks. When every bit
  // of a block propagates, the block carry-in is forwarded straight to the
  // block carry-out; the result is identical to a plain ripple chain.
  always_comb begin : slice_adder
    logic [7:0] p;
    logic [7:0] g;
    logic [8:0] c;
    p    = sl_a ^ sl_b;
    g    = sl_a & sl_b;
    c    = '0;
    c[0] = sl_cin;
    for (int blk = 0; blk < 2; blk++) begin
      for (int i = 0; i < 4; i++) begin
        c[blk*4+i+1] = g[blk*4+i] | (p[blk*4+i] & c[blk*4+i]);
      end
      if (&p[blk*4 +: 4]) begin
        c[blk*4+4] = c[blk*4];
      end
    end
    sl_sum  = p ^ c[7:0];
    sl_cout = c[8];
  end

  // State register plus all datapath registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic. DONE returns to IDLE only, so a new operand can never
  // be taken on the same edge the previous result is handed off.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)   state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: capture in IDLE, one byte per edge in RUN.
  always_comb begin
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
        end
      end
      RUN: begin
        sum_d[int'(idx_q)*SLICE +: SLICE] = sl_sum;
        carry_d = sl_cout;
        if (last_slice) begin
          // The top slice's carry ends here; it never wraps into slice 0.
          cout_d = sl_cout;
          ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sl_sum[7] != a_q[WIDTH-1]);
          idx_d  = '0;
        end else begin
          idx_d  = idx_q + IDXW'(1);
        end
      end
      default: ;
    endcase
  end

  // Handshake outputs are decoded purely from registered state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_csa_slice_seq_adder.sv
// Testbench for csa_slice_seq_adder: a WIDTH=32 instance driven through
// directed operations with a scoreboard of expected results, plus a WIDTH=8
// instance for the single-slice case.

module tb_csa_slice_seq_adder;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst;

  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] a, b, sum;
  logic        cin, cout, ovf;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8, sum8;
  logic        cin8, cout8, ovf8;

  exp_t        exp_q[$];
  int          n_compared;
  int          n_mismatched;

  csa_slice_seq_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  csa_slice_seq_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] simulation timeout");
  end

  // Reference model: plain full-width addition, no slicing.
  function automatic exp_t model32(input logic [31:0] x, input logic [31:0] y, input logic c);
    exp_t        e;
    logic [32:0] full;
    full   = {1'b0, x} + {1'b0, y} + {32'd0, c};
    e.sum  = full[31:0];
    e.cout = full[32];
    e.ovf  = (x[31] == y[31]) && (full[31] != x[31]);
    return e;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_compared++;
    assert (obs === expv) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed 0x%h required 0x%h", tag, obs, expv);
    end
  endtask

  // Offer one operand set to the 32-bit instance and record its expected result.
  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic c);
    int n;
    a = x; b = y; cin = c; in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkVal("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(model32(x, y, c));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'b1;
  endtask

  // Wait for the result, compare against the scoreboard, optionally hold
  // backpressure for 'hold' cycles while pulsing new operands, then drain.
  task automatic checkOutput(input int hold);
    exp_t e;
    int   n;
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkVal("latency", n, 32'd4);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkVal("sum",  sum, e.sum);
      checkVal("cout", {31'd0, cout}, {31'd0, e.cout});
      checkVal("ovf",  {31'd0, ovf},  {31'd0, e.ovf});
      checkVal("busy_done", {31'd0, busy}, 32'd1);
      for (int k = 0; k < hold; k++) begin
        in_valid = ~k[0];
        a = $urandom; b = $urandom; cin = k[1];
        @(negedge clk);
        checkVal("bp_out_valid", {31'd0, out_valid}, 32'd1);
        checkVal("bp_sum",       sum, e.sum);
        checkVal("bp_cout",      {31'd0, cout}, {31'd0, e.cout});
        checkVal("bp_ovf",       {31'd0, ovf},  {31'd0, e.ovf});
        checkVal("bp_in_ready",  {31'd0, in_ready}, 32'd0);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkVal("drain_out_valid", {31'd0, out_valid}, 32'd0);
    checkVal("drain_in_ready",  {31'd0, in_ready},  32'd1);
  endtask

  initial begin
    logic [8:0] full8;
    logic [7:0] ta8 [2];
    logic [7:0] tb8 [2];

    n_compared   = 0;
    n_mismatched = 0;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] reset state");
    checkVal("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkVal("rst_in_ready",  {31'd0, in_ready},  32'd1);
    checkVal("rst_busy",      {31'd0, busy},      32'd0);
    checkVal("rst_sum",       sum, 32'd0);
    checkVal("rst_cout",      {31'd0, cout}, 32'd0);
    checkVal("rst_ovf",       {31'd0, ovf},  32'd0);

    $display("[TB] directed operations");
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    checkOutput(0);
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    checkOutput(0);
    applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    checkOutput(0);
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0);
    checkOutput(0);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    checkOutput(0);

    $display("[TB] backpressure");
    applyStimulus(32'hDEAD_BEEF, 32'h0F0F_F0F0, 1'b1);
    checkOutput(5);

    $display("[TB] random operations");
    for (int i = 0; i < 4; i++) begin
      applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)));
      checkOutput(0);
    end

    $display("[TB] reset mid-run");
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    checkVal("abort_out_valid", {31'd0, out_valid}, 32'd0);
    checkVal("abort_sum",       sum, 32'd0);
    checkVal("abort_cout",      {31'd0, cout}, 32'd0);
    checkVal("abort_ovf",       {31'd0, ovf},  32'd0);
    checkVal("abort_in_ready",  {31'd0, in_ready}, 32'd1);
    applyStimulus(32'h0000_0005, 32'h0000_0003, 1'b0);
    checkOutput(0);

    $display("[TB] single-slice instance");
    ta8[0] = 8'h80; tb8[0] = 8'h80;
    ta8[1] = 8'h7F; tb8[1] = 8'h01;
    for (int i = 0; i < 2; i++) begin
      a8 = ta8[i]; b8 = tb8[i]; cin8 = 1'b0; in_valid8 = 1'b1;
      full8 = {1'b0, ta8[i]} + {1'b0, tb8[i]};
      checkVal("w8_in_ready", {31'd0, in_ready8}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid8 = 1'b0;
      checkVal("w8_busy_run", {31'd0, busy8}, 32'd1);
      @(negedge clk);
      checkVal("w8_out_valid", {31'd0, out_valid8}, 32'd1);
      checkVal("w8_sum",  {24'd0, sum8}, {24'd0, full8[7:0]});
      checkVal("w8_cout", {31'd0, cout8}, {31'd0, full8[8]});
      checkVal("w8_ovf",  {31'd0, ovf8},
               {31'd0, (ta8[i][7] == tb8[i][7]) && (full8[7] != ta8[i][7])});
      out_ready8 = 1'b1;
      @(negedge clk);
      out_ready8 = 1'b0;
      checkVal("w8_drain", {31'd0, out_valid8}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
